// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: TX prefetch FIFO feeding an SPI master, optional RX FIFO (SPI_XFER_CTRL_RX_EN).
// Latency: spi_tx_data is valid the cycle after spi_read; spi_start fires 2 cycles after the TX level is met.
module spi_xfer_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_go,
  input  logic [7:0]               cmd_len,
  input  logic [23:0]              cmd_ss_mask,
  output logic                     cmd_ready,
  output logic                     done,
  output logic                     tx_underrun,
  output logic                     rx_overflow,
  input  logic                     tx_wr_en,
  input  logic [7:0]               tx_wr_data,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_level,
  input  logic                     rx_rd_en,
  output logic [7:0]               rx_rd_data,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     spi_start,
  output logic [7:0]               spi_trans_len,
  output logic [23:0]              spi_ss_mask,
  input  logic                     spi_busy,
  input  logic                     spi_read,
  output logic [7:0]               spi_tx_data,
  input  logic                     spi_valid,
  input  logic [7:0]               spi_rx_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_START, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           seen_busy_q, seen_busy_d;
  logic [7:0]     len_q;
  logic [23:0]    mask_q;
  logic           go_acc;

  logic [7:0]     tx_mem [DEPTH];
  logic [AW-1:0]  tx_wp_q, tx_rp_q;
  logic [LW-1:0]  tx_cnt_q;
  logic [7:0]     tx_dat_q;
  logic           tx_unr_q;
  logic           tx_push, tx_pop, tx_empty;
  logic [8:0]     len_p1, need, tx_lvl9;

  assign go_acc        = cmd_go && (state_q == S_IDLE);
  assign cmd_ready     = (state_q == S_IDLE);
  assign spi_start     = (state_q == S_START);
  assign done          = (state_q == S_DONE);
  assign spi_trans_len = len_q;
  assign spi_ss_mask   = mask_q;

  assign tx_full     = (tx_cnt_q == LW'(DEPTH));
  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_level    = tx_cnt_q;
  assign tx_push     = tx_wr_en & ~tx_full;
  assign tx_pop      = spi_read & ~tx_empty;
  assign spi_tx_data = tx_dat_q;
  assign tx_underrun = tx_unr_q;

  // Long transfers only need a full FIFO before starting; the host streams the rest.
  assign len_p1  = {1'b0, len_q} + 9'd1;
  assign need    = (len_p1 > 9'(DEPTH)) ? 9'(DEPTH) : len_p1;
  assign tx_lvl9 = 9'(tx_cnt_q);

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      S_IDLE:     if (cmd_go) state_d = S_PREFETCH;
      S_PREFETCH: if (tx_lvl9 >= need) state_d = S_START;
      S_START: begin
        seen_busy_d = 1'b0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (spi_busy) seen_busy_d = 1'b1;
        if (seen_busy_q && !spi_busy) state_d = S_DONE;
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      seen_busy_q <= 1'b0;
      len_q       <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      if (go_acc) begin
        len_q  <= cmd_len;
        mask_q <= cmd_ss_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      tx_dat_q <= '0;
      tx_unr_q <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
      if (go_acc) tx_unr_q <= 1'b0;
      // Underrun wins over the clear; a same-cycle write into empty is still stored.
      if (spi_read) begin
        tx_dat_q <= tx_empty ? 8'h00 : tx_mem[tx_rp_q];
        if (tx_empty) tx_unr_q <= 1'b1;
      end
    end
  end

`ifdef SPI_XFER_CTRL_RX_EN
  logic [7:0]     rx_mem [DEPTH];
  logic [AW-1:0]  rx_wp_q, rx_rp_q;
  logic [LW-1:0]  rx_cnt_q;
  logic           rx_ovf_q, rx_full, rx_push, rx_pop;

  assign rx_full     = (rx_cnt_q == LW'(DEPTH));
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_level    = rx_cnt_q;
  assign rx_push     = spi_valid & ~rx_full;
  assign rx_pop      = rx_rd_en & ~rx_empty;
  assign rx_rd_data  = rx_mem[rx_rp_q];
  assign rx_overflow = rx_ovf_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= spi_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
      if (go_acc) rx_ovf_q <= 1'b0;
      if (spi_valid && rx_full) rx_ovf_q <= 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx   = ^{spi_valid, spi_rx_data, rx_rd_en};
  assign rx_rd_data  = 8'h00;
  assign rx_empty    = 1'b1;
  assign rx_level    = '0;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl (DEPTH=16); RX checks follow SPI_XFER_CTRL_RX_EN.
module tb_spi_xfer_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_go;
  logic [7:0]  cmd_len;
  logic [23:0] cmd_ss_mask;
  logic        cmd_ready, done, tx_underrun, rx_overflow;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        tx_full;
  logic [4:0]  tx_level;
  logic        rx_rd_en;
  logic [7:0]  rx_rd_data;
  logic        rx_empty;
  logic [4:0]  rx_level;
  logic        spi_start;
  logic [7:0]  spi_trans_len;
  logic [23:0] spi_ss_mask;
  logic        spi_busy, spi_read;
  logic [7:0]  spi_tx_data;
  logic        spi_valid;
  logic [7:0]  spi_rx_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  logic rd_d1 = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  spi_xfer_ctrl #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_go(cmd_go), .cmd_len(cmd_len), .cmd_ss_mask(cmd_ss_mask), .cmd_ready(cmd_ready),
    .done(done), .tx_underrun(tx_underrun), .rx_overflow(rx_overflow),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .spi_start(spi_start), .spi_trans_len(spi_trans_len), .spi_ss_mask(spi_ss_mask),
    .spi_busy(spi_busy), .spi_read(spi_read), .spi_tx_data(spi_tx_data),
    .spi_valid(spi_valid), .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_d1 <= spi_read;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT presents data.
  always @(negedge clk) begin
    if (rd_d1) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", 32'(spi_tx_data), 32'hFFFF_FFFF);
      else chk("spi_tx_data", 32'(spi_tx_data), 32'(exp_tx.pop_front()));
    end
    if (rx_rd_en && !rx_empty) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_rd_data), 32'hFFFF_FFFF);
      else chk("rx_rd_data", 32'(rx_rd_data), 32'(exp_rx.pop_front()));
    end
    if (spi_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    tx_wr_en = 1'b1; tx_wr_data = b;
    tick();
    tx_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] e);
    spi_read = 1'b1;
    exp_tx.push_back(e);
    tick();
    spi_read = 1'b0;
  endtask

  task automatic go(input logic [7:0] len, input logic [23:0] mask);
    cmd_go = 1'b1; cmd_len = len; cmd_ss_mask = mask;
    tick();
    cmd_go = 1'b0;
  endtask

  task automatic wait_start(input int base);
    for (int i = 0; i < 50 && start_cnt == base; i++) tick();
    chk("start_seen", 32'(start_cnt), 32'(base + 1));
  endtask

  task automatic finish_xfer();
    int base;
    base = done_cnt;
    spi_busy = 1'b0;
    for (int i = 0; i < 50 && done_cnt == base; i++) tick();
    chk("done_pulse", 32'(done_cnt), 32'(base + 1));
    tick();
    chk("done_once", 32'(done_cnt), 32'(base + 1));
    chk("idle_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int sb, w;
    rst_n = 1'b0; cmd_go = 1'b0; cmd_len = '0; cmd_ss_mask = '0;
    tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; spi_busy = 1'b0;
    spi_read = 1'b0; spi_valid = 1'b0; spi_rx_data = '0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_tx_data", 32'(spi_tx_data), 32'd0);
    chk("rst_mask", 32'(spi_ss_mask), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic 4-byte transfer
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    chk("lvl4", 32'(tx_level), 32'd4);
    sb = start_cnt;
    go(8'd3, 24'h000001);
    chk("busy_not_ready", 32'(cmd_ready), 32'd0);
    wait_start(sb);
    chk("trans_len", 32'(spi_trans_len), 32'd3);
    chk("ss_mask", 32'(spi_ss_mask), 32'h1);
    go(8'd9, 24'h000005);
    chk("go_ignored_len", 32'(spi_trans_len), 32'd3);
    spi_busy = 1'b1;
    rd(8'h11); rd(8'h22); rd(8'h33); rd(8'h44);
    tick();
    chk("start_once", 32'(start_cnt), 32'(sb + 1));
    chk("lvl0_after", 32'(tx_level), 32'd0);
    chk("no_underrun", 32'(tx_underrun), 32'd0);
    finish_xfer();

    // Prefetch waits for all 8 bytes
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    sb = start_cnt;
    go(8'd7, 24'h000002);
    for (int i = 0; i < 5; i++) tick();
    chk("prefetch_hold", 32'(start_cnt), 32'(sb));
    wr(8'hA4); wr(8'hA5); wr(8'hA6); wr(8'hA7);
    tick();
    chk("prefetch_hold7", 32'(start_cnt), 32'(sb));
    w = cyc;
    wr(8'hA8);
    wait_start(sb);
    chk("start_latency", 32'(start_cyc), 32'(w + 2));
    spi_busy = 1'b1;
    for (int i = 0; i < 8; i++) rd(8'(8'hA1 + i));
    finish_xfer();

    // 41-byte streamed transfer with DEPTH=16
    for (int i = 0; i < 15; i++) wr(8'(8'h40 + i));
    sb = start_cnt;
    go(8'd40, 24'h000004);
    for (int i = 0; i < 4; i++) tick();
    chk("long_hold15", 32'(start_cnt), 32'(sb));
    wr(8'h4F);
    wait_start(sb);
    chk("full_flag", 32'(tx_full), 32'd1);
    wr(8'hEE);
    chk("full_drop_lvl", 32'(tx_level), 32'd16);
    spi_busy = 1'b1;
    rd(8'h40);
    for (int j = 0; j < 25; j++) begin
      spi_read = 1'b1; tx_wr_en = 1'b1; tx_wr_data = 8'(8'h50 + j);
      exp_tx.push_back(8'(8'h41 + j));
      tick();
    end
    spi_read = 1'b0; tx_wr_en = 1'b0;
    chk("stream_lvl", 32'(tx_level), 32'd15);
    for (int j = 0; j < 15; j++) rd(8'(8'h5A + j));
    chk("stream_no_underrun", 32'(tx_underrun), 32'd0);
    chk("stream_lvl0", 32'(tx_level), 32'd0);
    finish_xfer();

    // Underrun, then write+pop into empty
    rd(8'h00);
    chk("underrun_set", 32'(tx_underrun), 32'd1);
    spi_read = 1'b1; tx_wr_en = 1'b1; tx_wr_data = 8'h5A;
    exp_tx.push_back(8'h00);
    tick();
    spi_read = 1'b0; tx_wr_en = 1'b0;
    chk("wr_pop_empty_lvl", 32'(tx_level), 32'd1);
    sb = start_cnt;
    go(8'd0, 24'hABCDEF);
    chk("underrun_clr", 32'(tx_underrun), 32'd0);
    chk("mask_abcdef", 32'(spi_ss_mask), 32'hABCDEF);
    wait_start(sb);
    spi_busy = 1'b1;
    rd(8'h5A);
    finish_xfer();

`ifdef SPI_XFER_CTRL_RX_EN
    for (int i = 0; i < 17; i++) begin
      spi_valid = 1'b1; spi_rx_data = 8'(8'hC0 + i);
      if (i < 16) exp_rx.push_back(8'(8'hC0 + i));
      tick();
    end
    spi_valid = 1'b0;
    chk("rx_lvl16", 32'(rx_level), 32'd16);
    chk("rx_ovf", 32'(rx_overflow), 32'd1);
    rx_rd_en = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    rx_rd_en = 1'b0;
    chk("rx_empty_end", 32'(rx_empty), 32'd1);
    chk("rx_lvl0", 32'(rx_level), 32'd0);
    chk("rx_all_read", 32'(exp_rx.size()), 32'd0);
`else
    spi_valid = 1'b1; spi_rx_data = 8'h33; rx_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    spi_valid = 1'b0; rx_rd_en = 1'b0;
    chk("norx_lvl", 32'(rx_level), 32'd0);
    chk("norx_empty", 32'(rx_empty), 32'd1);
    chk("norx_data", 32'(rx_rd_data), 32'd0);
    chk("norx_ovf", 32'(rx_overflow), 32'd0);
`endif

    // Reset during RUN
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    sb = start_cnt;
    go(8'd3, 24'h000008);
`ifdef SPI_XFER_CTRL_RX_EN
    chk("go_clears_ovf", 32'(rx_overflow), 32'd0);
`endif
    wait_start(sb);
    spi_busy = 1'b1;
    tick(); tick();
    w = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_lvl", 32'(tx_level), 32'd0);
    chk("mid_rst_len", 32'(spi_trans_len), 32'd0);
    chk("mid_rst_mask", 32'(spi_ss_mask), 32'd0);
    chk("mid_rst_start", 32'(spi_start), 32'd0);
    spi_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("no_done_after_rst", 32'(done_cnt), 32'(w));
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_lvl", 32'(tx_level), 32'd0);
    chk("post_rst_rx_lvl", 32'(rx_level), 32'd0);
    chk("tx_sb_drained", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning TX and RX FIFO depth in bytes (power of two, 4..256).
REQ-002 SHALL have ports `clk`, input, 1 bit, the single clock; `rst_n`, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have ports `cmd_go`, input, 1 bit (transfer request); `cmd_len`, input, 8 bits (bytes minus one); `cmd_ss_mask`, input, 24 bits (slave selects); `cmd_ready`, output, 1 bit (idle).
REQ-004 SHALL have ports `done`, output, 1 bit (transfer-complete pulse); `tx_underrun`, output, 1 bit (sticky); `rx_overflow`, output, 1 bit (sticky).
REQ-005 SHALL have TX host ports `tx_wr_en`, input, 1; `tx_wr_data`, input, 8; `tx_full`, output, 1; `tx_level`, output, log2(DEPTH)+1 bits.
REQ-006 SHALL have RX host ports `rx_rd_en`, input, 1; `rx_rd_data`, output, 8 (show-ahead head); `rx_empty`, output, 1; `rx_level`, output, log2(DEPTH)+1 bits.
REQ-007 SHALL have SPI-master-side ports `spi_start`, output, 1; `spi_trans_len`, output, 8; `spi_ss_mask`, output, 24; `spi_busy`, input, 1; `spi_read`, input, 1; `spi_tx_data`, output, 8; `spi_valid`, input, 1; `spi_rx_data`, input, 8.

Function
REQ-008 SHALL implement FSM IDLE -> PREFETCH -> START -> RUN -> DONE -> IDLE.
REQ-009 IDLE: `cmd_ready`=1; `cmd_go` latches `cmd_len`/`cmd_ss_mask` into `spi_trans_len`/`spi_ss_mask`, clears both sticky flags, goes to PREFETCH; `cmd_go` in any other state is ignored.
REQ-010 PREFETCH: waits until `tx_level` >= min(`cmd_len`+1, DEPTH), then goes to START.
REQ-011 START: `spi_start`=1 for exactly one cycle, then goes to RUN.
REQ-012 RUN: sets internal `seen_busy` when `spi_busy`=1; goes to DONE on the first cycle with `seen_busy`=1 and `spi_busy`=0.
REQ-013 DONE: `done`=1 for exactly one cycle, then returns to IDLE.
REQ-014 TX write SHALL be accepted iff `tx_wr_en`=1 and registered `tx_full`=0; writes while full are dropped silently.
REQ-015 `spi_read`=1 SHALL pop the TX head into registered `spi_tx_data`, valid the cycle after `spi_read`, held until the next pop.
REQ-016 `spi_read` with TX empty SHALL load `spi_tx_data`=8'h00 and set `tx_underrun`.
REQ-017 Simultaneous TX write and pop SHALL both take effect; level is unchanged; write into empty plus pop yields underrun (write stored).
REQ-018 `spi_valid`=1 SHALL push `spi_rx_data` into RX FIFO; push while RX is full SHALL drop the byte and set `rx_overflow`.
REQ-019 `rx_rd_en` SHALL pop when `rx_empty`=0, otherwise it is ignored; simultaneous push and pop on full RX SHALL pop, with the push dropped and `rx_overflow` set.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; levels SHALL range 0..DEPTH; `tx_full`=(`tx_level`==DEPTH); `rx_empty`=(`rx_level`==0).
REQ-021 Host TX writes and RX reads SHALL remain legal in every FSM state (streaming transfers longer than DEPTH).

Reset
REQ-022 On `rst_n`=0 the block SHALL asynchronously enter IDLE, empty both FIFOs, and clear `spi_start`, `done`, both sticky flags, `spi_tx_data`, `spi_trans_len` and `seen_busy`, with `spi_ss_mask`=0 and `cmd_ready`=1 after release.
REQ-023 Reset mid-transfer SHALL discard all FIFO contents; no `done` is issued.

Configuration
REQ-024 Macro SPI_XFER_CTRL_RX_EN SHALL, when defined, compile in the RX FIFO per REQ-018/019.
REQ-025 Without SPI_XFER_CTRL_RX_EN, `spi_valid`/`spi_rx_data`/`rx_rd_en` SHALL be ignored, with `rx_rd_data`=0, `rx_empty`=1, `rx_level`=0, `rx_overflow`=0 constant.

Verification
REQ-026 Write 4 bytes 11,22,33,44, then `cmd_go` with `cmd_len`=3 and mask 24'h000001 -> `spi_start` pulses once; successive `spi_read` yields `spi_tx_data` 11,22,33,44 one cycle later; `done` follows the busy fall.
REQ-027 `cmd_go` with `cmd_len`=7 and only 3 bytes written -> stays in PREFETCH, no `spi_start`; the 8th-byte write leads to `spi_start` 2 cycles later.
REQ-028 `cmd_len`=40 with DEPTH=16 -> starts at `tx_level`=16; continued writes during RUN give no underrun.
REQ-029 Push 17 bytes via `spi_valid` with no reads (DEPTH=16) -> `rx_level`=16, `rx_overflow`=1, and `rx_rd_data` reads back the first 16 bytes in order.
REQ-030 `spi_read` with TX empty -> `spi_tx_data`=00 and `tx_underrun`=1; the next `cmd_go` clears it.
REQ-031 Assert `rst_n`=0 during RUN -> all outputs at reset values, levels 0, and no `done`.
